prescaler: RTL and testbench

- Free-running binary clock divider: an N-bit up-counter clocked by the system clock.
- Its MSB is the divided clock: period 2^N input cycles, 50% duty.
- Used by I/O blocks to derive slow strobes (e.g. N=16 at 50 MHz gives ~763 Hz for 7-segment display multiplexing).
- Also provides a one-cycle wrap pulse and the raw count, so single-clock-domain users need not treat the divided output as a clock.

---
 rtl/prescaler.sv | 35 +++
 tb/tb_prescaler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/prescaler.sv
// Free-running N-bit binary prescaler: the counter MSB is a 50% duty divided clock,
// with a one-cycle wrap strobe and the raw count for same-domain users.
module prescaler #(
   parameter int N = 16
) (
   input  logic         clk,
   output logic         out,
   input  logic         rst_,
   output logic         tick,
   output logic [N-1:0] count
);

   generate
      if ((N < 1) || (N > 32)) begin : g_bad_width
         $error("prescaler: N must be in 1..32");
      end
   endgenerate

   logic [N-1:0] count_reg;

   // Carry out of the top bit is dropped, so the counter wraps modulo 2^N.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + N'(1);
      end
   end

   // out comes straight off a flop bit, so it stays glitch-free.
   assign out   = count_reg[N-1];
   assign tick  = &count_reg;
   assign count = count_reg;

endmodule

// File: tb/tb_prescaler.sv
// Directed bench for prescaler: N=4 reset/run/tick/mid-reset, N=1 toggle, N=16 wrap.
`timescale 1ns/1ps
module tb_prescaler;

   logic        clk = 1'b0;
   logic        rst4 = 1'b1;
   logic        rst1 = 1'b1;
   logic        rst16 = 1'b1;
   logic        out4, tick4;
   logic [3:0]  count4;
   logic        out1, tick1;
   logic [0:0]  count1;
   logic        out16, tick16;
   logic [15:0] count16;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   prescaler #(.N(4)) dut4 (
      .clk(clk), .out(out4), .rst_(rst4), .tick(tick4), .count(count4)
   );
   prescaler #(.N(1)) dut1 (
      .clk(clk), .out(out1), .rst_(rst1), .tick(tick1), .count(count1)
   );
   prescaler dut16 (
      .clk(clk), .out(out16), .rst_(rst16), .tick(tick16), .count(count16)
   );

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (count4 !== 4'd0) begin n_fail++; $display("FAIL reset_count4: got %0d expected 0", count4); end
      n_checks++; if (out4 !== 1'b0) begin n_fail++; $display("FAIL reset_out4: got %b expected 0", out4); end
      n_checks++; if (tick4 !== 1'b0) begin n_fail++; $display("FAIL reset_tick4: got %b expected 0", tick4); end
      n_checks++; if (out1 !== 1'b0 || tick1 !== 1'b0) begin n_fail++; $display("FAIL reset_n1: got out=%b tick=%b expected 0/0", out1, tick1); end
      n_checks++; if (count16 !== 16'd0) begin n_fail++; $display("FAIL reset_count16: got %0h expected 0", count16); end
      $display("reset held 3 clks: count4=%0d out4=%b tick4=%b", count4, out4, tick4);
      @(negedge clk) rst4 = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      n_checks++; if (count4 !== 4'd9) begin n_fail++; $display("FAIL pre_async_count: got %0d expected 9", count4); end
      #2 rst4 = 1'b0;
      #1;
      n_checks++; if (count4 !== 4'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", count4); end
      n_checks++; if (out4 !== 1'b0) begin n_fail++; $display("FAIL async_reset_out: got %b expected 0", out4); end
      $display("async reset at count 9 between edges: count4=%0d out4=%b", count4, out4);
   endtask

   task automatic test_free_run;
      int rise1 = -1, fall1 = -1, rise2 = -1;
      logic prev_out = 1'b0;
      logic [3:0] exp_count;
      @(negedge clk) rst4 = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         exp_count = 4'(e % 16);
         n_checks++; if (count4 !== exp_count) begin n_fail++; $display("FAIL run_count edge %0d: got %0d expected %0d", e, count4, exp_count); end
         n_checks++; if (out4 !== (exp_count >= 4'd8)) begin n_fail++; $display("FAIL run_out edge %0d: got %b expected %b", e, out4, exp_count >= 4'd8); end
         if (!prev_out && out4) begin
            if (rise1 < 0) rise1 = e; else if (rise2 < 0) rise2 = e;
         end
         if (prev_out && !out4 && fall1 < 0) fall1 = e;
         prev_out = out4;
      end
      $display("free run: out rises at %0d and %0d, falls at %0d", rise1, rise2, fall1);
      n_checks++; if (rise1 != 8) begin n_fail++; $display("FAIL first_rise: got %0d expected 8", rise1); end
      n_checks++; if (fall1 != 16) begin n_fail++; $display("FAIL first_fall: got %0d expected 16", fall1); end
      n_checks++; if (rise2 != 24) begin n_fail++; $display("FAIL second_rise: got %0d expected 24", rise2); end
      n_checks++; if (rise2 - rise1 != 16) begin n_fail++; $display("FAIL out_period: got %0d expected 16", rise2 - rise1); end
      n_checks++; if (fall1 - rise1 != 8) begin n_fail++; $display("FAIL out_high_time: got %0d expected 8", fall1 - rise1); end
   endtask

   task automatic test_tick;
      int ticks = 0;
      logic prev_tick = 1'b0;
      for (int e = 0; e < 48; e++) begin
         @(posedge clk);
         #1;
         if (prev_tick) begin
            n_checks++; if (count4 !== 4'd0 || out4 !== 1'b0) begin n_fail++; $display("FAIL after_tick: got count=%0d out=%b expected 0/0", count4, out4); end
         end
         if (tick4 === 1'b1) begin
            ticks++;
            n_checks++; if (count4 !== 4'd15) begin n_fail++; $display("FAIL tick_count: got %0d expected 15", count4); end
         end else begin
            n_checks++; if (count4 === 4'd15) begin n_fail++; $display("FAIL tick_missing: got tick=%b expected 1 at count 15", tick4); end
         end
         prev_tick = tick4;
      end
      $display("tick over 48 clks: %0d pulses", ticks);
      n_checks++; if (ticks != 3) begin n_fail++; $display("FAIL tick_pulses: got %0d expected 3", ticks); end
   endtask

   task automatic test_mid_reset;
      bit found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (count4 === 4'd13) begin found = 1'b1; break; end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL reach_13: got count=%0d expected 13 within 20 clks", count4); end
      n_checks++; if (out4 !== 1'b1) begin n_fail++; $display("FAIL out_at_13: got %b expected 1", out4); end
      #2 rst4 = 1'b0;
      #1;
      n_checks++; if (out4 !== 1'b0 || count4 !== 4'd0) begin n_fail++; $display("FAIL mid_reset: got out=%b count=%0d expected 0/0", out4, count4); end
      @(posedge clk);
      #1;
      n_checks++; if (count4 !== 4'd0) begin n_fail++; $display("FAIL reset_hold: got %0d expected 0", count4); end
      @(negedge clk) rst4 = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk);
         #1;
         n_checks++; if (out4 !== (e == 8)) begin n_fail++; $display("FAIL post_reset_out edge %0d: got %b expected %b", e, out4, e == 8); end
      end
      $display("mid-run reset at 13: out back high after 8 edges, count4=%0d", count4);
   endtask

   task automatic test_n1;
      logic exp;
      @(negedge clk) rst1 = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk);
         #1;
         exp = (e % 2) == 1;
         n_checks++; if (out1 !== exp) begin n_fail++; $display("FAIL n1_out edge %0d: got %b expected %b", e, out1, exp); end
         n_checks++; if (tick1 !== exp) begin n_fail++; $display("FAIL n1_tick edge %0d: got %b expected %b", e, tick1, exp); end
         n_checks++; if (count1 !== exp) begin n_fail++; $display("FAIL n1_count edge %0d: got %b expected %b", e, count1, exp); end
      end
      $display("N=1: 10 clks toggled, last out=%b tick=%b", out1, tick1);
   endtask

   task automatic test_n16;
      int bad = 0, ticks = 0, rises = 0, rise_at = -1;
      logic prev_out = 1'b0;
      logic [15:0] exp;
      @(negedge clk) rst16 = 1'b1;
      for (int e = 1; e <= 65537; e++) begin
         @(posedge clk);
         #1;
         exp = 16'(e % 65536);
         if (count16 !== exp) bad++;
         if (tick16 === 1'b1) ticks++;
         if (!prev_out && out16) begin rises++; if (rise_at < 0) rise_at = e; end
         prev_out = out16;
         if (e == 65535) begin
            n_checks++; if (count16 !== 16'hFFFF || tick16 !== 1'b1 || out16 !== 1'b1) begin n_fail++; $display("FAIL n16_top: got count=%0h tick=%b out=%b expected ffff/1/1", count16, tick16, out16); end
         end
         if (e == 65536) begin
            n_checks++; if (count16 !== 16'h0000 || tick16 !== 1'b0 || out16 !== 1'b0) begin n_fail++; $display("FAIL n16_wrap: got count=%0h tick=%b out=%b expected 0/0/0", count16, tick16, out16); end
         end
      end
      $display("N=16: %0d bad counts, %0d ticks, %0d out rises (first at %0d)", bad, ticks, rises, rise_at);
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL n16_sequence: got %0d bad counts expected 0", bad); end
      n_checks++; if (ticks != 1) begin n_fail++; $display("FAIL n16_ticks: got %0d expected 1", ticks); end
      n_checks++; if (rise_at != 32768) begin n_fail++; $display("FAIL n16_rise: got %0d expected 32768", rise_at); end
      n_checks++; if (rises != 1) begin n_fail++; $display("FAIL n16_rises: got %0d expected 1", rises); end
   endtask

   initial begin
      #1;
      rst4 = 1'b0;
      rst1 = 1'b0;
      rst16 = 1'b0;
      test_reset();
      test_free_run();
      test_tick();
      test_mid_reset();
      test_n1();
      test_n16();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish before 2000000 ns");
      $fatal(1, "timeout");
   end

endmodule
